// File: rtl/wide_dec_fmt_pkg.sv
// Shared constants for the wide decimal formatter: state codes, ASCII values
// and the decimal digit-count helper.
package wide_dec_fmt_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t DIV  = 2'd1;
  localparam state_t EMIT = 2'd2;

  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // Maximum decimal digits of a width-bit unsigned value (log10(2) ~ 0.30103).
  function automatic int unsigned ndig(input int unsigned width);
    return (width * 32'd30103) / 32'd100000 + 32'd1;
  endfunction

endpackage

// File: rtl/div10_step.sv
// Combinational divide-by-10 slice: restoring subtract over STEP dividend bits,
// carrying a 4-bit remainder (always < 10) from the previous slice.
module div10_step #(
  parameter int unsigned STEP = 8
) (
  input  logic [3:0]      rem_in,
  input  logic [STEP-1:0] din,
  output logic [STEP-1:0] quo,
  output logic [3:0]      rem_out
);

  logic [3:0] acc;
  logic [4:0] trial;

  // One restoring subtract per dividend bit, MSB first.
  always_comb begin
    acc   = rem_in;
    trial = 5'd0;
    quo   = '0;
    for (int i = int'(STEP) - 1; i >= 0; i--) begin
      trial = {acc, din[i]};
      if (trial >= 5'd10) begin
        quo[i] = 1'b1;
        acc    = 4'(trial - 5'd10);
      end else begin
        acc    = trial[3:0];
      end
    end
    rem_out = acc;
  end

endmodule

// File: rtl/wide_dec_fmt_seq.sv
// Wide unsigned to decimal ASCII formatter, most significant digit first.
// Repeated divide-by-10 passes push remainders on a LIFO, which is then
// drained through a valid/ready character stream.
// Optional: WIDE_DEC_FMT_PAD_EN left-pads every value with spaces to NDIG chars.
module wide_dec_fmt_seq
  import wide_dec_fmt_pkg::*;
#(
  parameter int unsigned WIDTH = 1024,
  parameter int unsigned STEP  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned NDIG  = ndig(WIDTH);
  localparam int unsigned NPASS = WIDTH / STEP;
  localparam int unsigned CW    = $clog2(NDIG + 1);
  localparam int unsigned SW    = $clog2(NDIG);
  localparam int unsigned PW    = $clog2(NPASS + 1);

  state_t           state, state_d;
  logic [WIDTH-1:0] dvd, dvd_d;
  logic [WIDTH-1:0] quo, quo_d;
  logic [3:0]       rem, rem_d;
  logic [PW-1:0]    step_cnt, step_cnt_d;
  logic [CW-1:0]    count, count_d;
  logic             in_ready_d, out_valid_d, out_last_d, busy_d;
  logic [7:0]       out_char_d;
  logic             push;

  logic [3:0]       stack [NDIG];

  logic [STEP-1:0]  q_bits;
  logic [3:0]       rem_nx;
  logic [WIDTH-1:0] quo_shift;
  logic [CW-1:0]    count_inc;
  logic [3:0]       top_dig;

`ifdef WIDE_DEC_FMT_PAD_EN
  logic [CW-1:0]    pad_cnt, pad_cnt_d;
`endif

  div10_step #(.STEP(STEP)) u_step (
    .rem_in  (rem),
    .din     (dvd[WIDTH-1 -: STEP]),
    .quo     (q_bits),
    .rem_out (rem_nx)
  );

  assign quo_shift = WIDTH'({quo, q_bits});
  assign count_inc = count + CW'(1);
  assign top_dig   = stack[SW'(count - CW'(1))];

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state;
    dvd_d       = dvd;
    quo_d       = quo;
    rem_d       = rem;
    step_cnt_d  = step_cnt;
    count_d     = count;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    out_char_d  = out_char;
    out_last_d  = out_last;
    busy_d      = busy;
    push        = 1'b0;
`ifdef WIDE_DEC_FMT_PAD_EN
    pad_cnt_d   = pad_cnt;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          dvd_d      = in_data;
          quo_d      = '0;
          rem_d      = '0;
          step_cnt_d = '0;
          count_d    = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = DIV;
        end
      end
      DIV: begin
        dvd_d      = dvd << STEP;
        quo_d      = quo_shift;
        rem_d      = rem_nx;
        step_cnt_d = step_cnt + PW'(1);
        if (step_cnt == PW'(NPASS - 1)) begin
          push       = 1'b1;
          count_d    = count_inc;
          step_cnt_d = '0;
          rem_d      = '0;
          if (quo_shift == '0) begin
            state_d     = EMIT;
            out_valid_d = 1'b1;
            out_char_d  = CHAR_ZERO + {4'd0, rem_nx};
            out_last_d  = (count_inc == CW'(1));
`ifdef WIDE_DEC_FMT_PAD_EN
            pad_cnt_d   = CW'(NDIG) - count_inc;
            if (pad_cnt_d != '0) begin
              out_char_d = CHAR_SPACE;
              out_last_d = 1'b0;
            end
`endif
          end else begin
            dvd_d = quo_shift;
            quo_d = '0;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
`ifdef WIDE_DEC_FMT_PAD_EN
          if (pad_cnt != '0) begin
            pad_cnt_d = pad_cnt - CW'(1);
            if (pad_cnt_d != '0) begin
              out_char_d = CHAR_SPACE;
              out_last_d = 1'b0;
            end else begin
              out_char_d = CHAR_ZERO + {4'd0, top_dig};
              out_last_d = (count == CW'(1));
            end
          end else
`endif
          begin
            if (count == CW'(1)) begin
              state_d     = IDLE;
              count_d     = '0;
              out_valid_d = 1'b0;
              out_char_d  = 8'h00;
              out_last_d  = 1'b0;
              in_ready_d  = 1'b1;
              busy_d      = 1'b0;
            end else begin
              count_d    = count - CW'(1);
              out_char_d = CHAR_ZERO + {4'd0, stack[SW'(count - CW'(2))]};
              out_last_d = (count == CW'(2));
            end
          end
        end
      end
      default: begin
        state_d     = IDLE;
        count_d     = '0;
        out_valid_d = 1'b0;
        out_char_d  = 8'h00;
        out_last_d  = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dvd       <= '0;
      quo       <= '0;
      rem       <= '0;
      step_cnt  <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      out_last  <= 1'b0;
      busy      <= 1'b0;
`ifdef WIDE_DEC_FMT_PAD_EN
      pad_cnt   <= '0;
`endif
    end else begin
      state     <= state_d;
      dvd       <= dvd_d;
      quo       <= quo_d;
      rem       <= rem_d;
      step_cnt  <= step_cnt_d;
      count     <= count_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_char  <= out_char_d;
      out_last  <= out_last_d;
      busy      <= busy_d;
`ifdef WIDE_DEC_FMT_PAD_EN
      pad_cnt   <= pad_cnt_d;
`endif
    end
  end

  // Digit LIFO; contents are meaningless once count is cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      stack[SW'(count)] <= rem_nx;
    end
  end

endmodule
